game_sequencer: RTL
===================

// Module: game_sequencer
// PURPOSE
//   Brick-lifecycle controller for the playfield datapath: spawn, move/rotate requests, gravity, lock, line clear, game over.
//   Owns the active brick (pos/dir/type) and drives try_* into collision_check.
//   Reads is_collided back combinationally, then pulses place_en / clear_en to the board-update logic.
//   Placement always uses the drop-shadow position.
//   Sits between keyboard (key_press_1plus) and board/clear/drop datapath; runs on main_clk.
// PARAMETERS
//   GRAVITY_TICKS  32   WAIT-state cycles per automatic one-row drop (>=2)
//   SPAWN_X        6    spawn column
//   SPAWN_Y        18   spawn row
// PORTS
//   clk            in   1                main clock; all state on posedge
//   rst_n          in   1                asynchronous, active-low reset
//   start          in   1                1-cycle pulse: begin new game (IDLE or OVER only)
//   key_press      in   KEY_PRESS_LEN    1-cycle key pulses, KEY_* indices
//   next_type      in   BRICK_LEN        type for next spawn (1..7), sampled in SPAWN
//   is_collided    in   1                collision_check result for current try_* (combinational)
//   num_to_clear   in   5                full rows in board after place, valid in CLEAR
//   cur_pos        out  POS_LEN          active brick position
//   cur_dir        out  DIR_LEN          active brick direction
//   cur_type       out  BRICK_LEN        active brick type
//   try_pos        out  POS_LEN          candidate position under test
//   try_dir        out  DIR_LEN          candidate direction under test
//   try_type       out  BRICK_LEN        candidate type under test
//   place_en       out  1                1-cycle: write shadow brick into board
//   clear_en       out  1                1-cycle: load cleared_board into board
//   lines          out  16               total rows cleared, saturating
//   score          out  16               score, saturating
//   game_over      out  1                high while in OVER
//   state          out  3                SEQ_* encoding (debug / seven-segment)
// BEHAVIOUR
//   Reset: state=IDLE; cur/try = MAKE_POS(SPAWN_X,SPAWN_Y), dir 0, BRICK_I; lines=score=0; place_en=clear_en=game_over=0; gravity cnt=0.
//   States: IDLE, SPAWN, WAIT, CHECK, PLACE, CLEAR, OVER.
//   IDLE:  start -> SPAWN, clearing lines/score.
//   SPAWN: cur=try=(spawn pos, dir 0, next_type); kind=K_SPAWN -> CHECK.
//   WAIT:  gravity cnt increments each cycle. One request per cycle; the others are dropped.
//     Priority: SPACE > gravity expiry (cnt==GRAVITY_TICKS-1) > RIGHT_1 (dir+1, wraps) > LEFT (x-1) > RIGHT (x+1) > DOWN (y-1).
//     SPACE -> PLACE directly. All other requests load try_*, record kind, -> CHECK.
//     Latency: request to commit is 2 cycles.
//   CHECK: sample is_collided (try_* stable since previous edge).
//     Clear -> commit try_* to cur_*; if kind is GRAV or DOWN, gravity cnt=0.
//     Collided -> K_GRAV/K_DOWN: PLACE (lock); K_SPAWN: OVER; K_ROT/LEFT/RIGHT: discard, try_* := cur_*.
//     Non-lock, non-over paths -> WAIT.
//   PLACE: place_en=1 for exactly one cycle -> CLEAR.
//   CLEAR: clear_en=1 for one cycle; n = min(num_to_clear,4).
//     lines += n; score += SCORE_TAB[n] = {0,1,3,5,8}; both saturate at 16'hFFFF.
//     gravity cnt=0 -> SPAWN.
//   OVER:  game_over=1; keys ignored; start -> SPAWN with lines/score cleared.
//   Key pulses arriving outside WAIT are ignored; nothing is queued.
//   x/y arithmetic is modulo field width; off-board candidates must be flagged by collision_check.
//   start while in WAIT..CLEAR is ignored.
//   rst_n low at any time returns to the reset values immediately (asynchronous); no partial place/clear pulse follows.
// STRUCTURE
//   header.v additions: SEQ_IDLE..SEQ_OVER (3b), K_SPAWN/K_GRAV/K_DOWN/K_ROT/K_LEFT/K_RIGHT (3b), SCORE_TAB entries.
//   Existing macros used as-is: KEY_*, MAKE_POS, GETX/GETY, POS_LEN, DIR_LEN, BRICK_*.
//   Sub-module gravity_timer: counter with clear and enable inputs, expiry pulse output; parameter GRAVITY_TICKS.
//   Single always_ff/always @* pair for the FSM; score/lines adders inline.
// TESTING
//   1 Reset, start, next_type=3, is_collided=0 -> SPAWN; cur=(6,18,dir0,type3); WAIT within 2 cycles.
//   2 LEFT pulse in WAIT, is_collided=0 -> cur_pos x=5 two cycles later.
//     Repeat with is_collided=1 -> cur unchanged, try_pos returns to cur_pos.
//   3 GRAVITY_TICKS=4, no keys -> cur y decrements every 4+1 cycles.
//     Next gravity request with is_collided=1 -> place_en 1 cycle, then clear_en 1 cycle, then SPAWN.
//   4 SPACE and LEFT in same cycle -> PLACE next cycle, x unchanged.
//     num_to_clear=4 at CLEAR -> lines+=4, score+=8.
//   5 SPAWN with is_collided=1 -> OVER, game_over=1, keys ignored; start -> SPAWN, score=lines=0.
//   6 rst_n low during CHECK and during PLACE -> all outputs at reset values, no place_en.
//     Also: score preset 16'hFFFC plus a 4-line clear -> saturates at 16'hFFFF.

Source files
------------

// File: rtl/game_sequencer_pkg.sv
// Shared definitions for the brick-lifecycle sequencer: key indices, position
// packing, FSM state and request-kind encodings, and the line-clear score table.
package game_sequencer_pkg;

  localparam int KEY_PRESS_LEN = 5;
  localparam int KEY_LEFT      = 0;
  localparam int KEY_RIGHT     = 1;
  localparam int KEY_DOWN      = 2;
  localparam int KEY_RIGHT_1   = 3;
  localparam int KEY_SPACE     = 4;

  localparam int COORD_LEN = 5;
  localparam int POS_LEN   = 2 * COORD_LEN;
  localparam int DIR_LEN   = 2;
  localparam int BRICK_LEN = 3;

  localparam logic [BRICK_LEN-1:0] BRICK_I = 3'd1;

  typedef enum logic [2:0] {
    SEQ_IDLE  = 3'd0,
    SEQ_SPAWN = 3'd1,
    SEQ_WAIT  = 3'd2,
    SEQ_CHECK = 3'd3,
    SEQ_PLACE = 3'd4,
    SEQ_CLEAR = 3'd5,
    SEQ_OVER  = 3'd6
  } seq_state_e;

  typedef enum logic [2:0] {
    K_SPAWN = 3'd0,
    K_GRAV  = 3'd1,
    K_DOWN  = 3'd2,
    K_ROT   = 3'd3,
    K_LEFT  = 3'd4,
    K_RIGHT = 3'd5
  } kind_e;

  // Points awarded for clearing n rows at once (n already clamped to 0..4).
  function automatic logic [15:0] score_tab(input logic [2:0] n);
    case (n)
      3'd1:    return 16'd1;
      3'd2:    return 16'd3;
      3'd3:    return 16'd5;
      3'd4:    return 16'd8;
      default: return 16'd0;
    endcase
  endfunction

  // Position is packed as {x, y}; coordinate arithmetic wraps at the field width.
  function automatic logic [POS_LEN-1:0] make_pos(input logic [COORD_LEN-1:0] x,
                                                  input logic [COORD_LEN-1:0] y);
    return {x, y};
  endfunction

  function automatic logic [COORD_LEN-1:0] get_x(input logic [POS_LEN-1:0] p);
    return p[POS_LEN-1:COORD_LEN];
  endfunction

  function automatic logic [COORD_LEN-1:0] get_y(input logic [POS_LEN-1:0] p);
    return p[COORD_LEN-1:0];
  endfunction

endpackage

// File: rtl/game_sequencer_gravity_timer.sv
// Gravity tick counter: counts enabled cycles, flags the cycle on which the
// automatic one-row drop is due. Clear has priority over enable.
module game_sequencer_gravity_timer #(
  parameter int GRAVITY_TICKS = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CNT_W = $clog2(GRAVITY_TICKS) + 1;

  logic [CNT_W-1:0] r_cnt;

  // Tick counter: cleared on commit of a downward move or after a line clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_expire = i_en && (r_cnt == CNT_W'(GRAVITY_TICKS - 1));

endmodule

// File: rtl/game_sequencer.sv
// Brick-lifecycle controller: spawns bricks, turns key/gravity requests into
// candidate positions for the collision checker, commits or rejects them, and
// pulses place/clear strobes to the board datapath while tracking lines/score.
module game_sequencer
  import game_sequencer_pkg::*;
#(
  parameter int GRAVITY_TICKS = 32,
  parameter int SPAWN_X       = 6,
  parameter int SPAWN_Y       = 18
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [KEY_PRESS_LEN-1:0] key_press,
  input  logic [BRICK_LEN-1:0]     next_type,
  input  logic                     is_collided,
  input  logic [4:0]               num_to_clear,
  output logic [POS_LEN-1:0]       cur_pos,
  output logic [DIR_LEN-1:0]       cur_dir,
  output logic [BRICK_LEN-1:0]     cur_type,
  output logic [POS_LEN-1:0]       try_pos,
  output logic [DIR_LEN-1:0]       try_dir,
  output logic [BRICK_LEN-1:0]     try_type,
  output logic                     place_en,
  output logic                     clear_en,
  output logic [15:0]              lines,
  output logic [15:0]              score,
  output logic                     game_over,
  output logic [2:0]               state
);

  localparam logic [POS_LEN-1:0] SPAWN_POS = {COORD_LEN'(SPAWN_X), COORD_LEN'(SPAWN_Y)};

  seq_state_e           r_state,    w_state_n;
  kind_e                r_kind,     w_kind_n;
  logic [POS_LEN-1:0]   r_cur_pos,  w_cur_pos_n,  r_try_pos,  w_try_pos_n;
  logic [DIR_LEN-1:0]   r_cur_dir,  w_cur_dir_n,  r_try_dir,  w_try_dir_n;
  logic [BRICK_LEN-1:0] r_cur_type, w_cur_type_n, r_try_type, w_try_type_n;
  logic [15:0]          r_lines,    w_lines_n,    r_score,    w_score_n;
  logic                 w_grav_clr, w_grav_expire;
  logic [COORD_LEN-1:0] w_cur_x,    w_cur_y;
  logic [2:0]           w_n_clr;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  game_sequencer_gravity_timer #(
    .GRAVITY_TICKS (GRAVITY_TICKS)
  ) u_gravity_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_grav_clr),
    .i_en     (r_state == SEQ_WAIT),
    .o_expire (w_grav_expire)
  );

  assign w_cur_x = get_x(r_cur_pos);
  assign w_cur_y = get_y(r_cur_pos);
  assign w_n_clr = (num_to_clear > 5'd4) ? 3'd4 : num_to_clear[2:0];

  // Next-state and next-brick logic; every request path re-bases on cur_*.
  always_comb begin
    w_state_n    = r_state;
    w_kind_n     = r_kind;
    w_cur_pos_n  = r_cur_pos;
    w_cur_dir_n  = r_cur_dir;
    w_cur_type_n = r_cur_type;
    w_try_pos_n  = r_try_pos;
    w_try_dir_n  = r_try_dir;
    w_try_type_n = r_try_type;
    w_lines_n    = r_lines;
    w_score_n    = r_score;
    w_grav_clr   = 1'b0;
    case (r_state)
      SEQ_IDLE, SEQ_OVER: begin
        if (start) begin
          w_state_n = SEQ_SPAWN;
          w_lines_n = '0;
          w_score_n = '0;
        end
      end
      SEQ_SPAWN: begin
        w_cur_pos_n  = SPAWN_POS;
        w_cur_dir_n  = '0;
        w_cur_type_n = next_type;
        w_try_pos_n  = SPAWN_POS;
        w_try_dir_n  = '0;
        w_try_type_n = next_type;
        w_kind_n     = K_SPAWN;
        w_state_n    = SEQ_CHECK;
      end
      SEQ_WAIT: begin
        if (key_press[KEY_SPACE]) begin
          w_state_n = SEQ_PLACE;
        end else if (w_grav_expire) begin
          w_try_pos_n = make_pos(w_cur_x, w_cur_y - COORD_LEN'(1));
          w_kind_n    = K_GRAV;
          w_state_n   = SEQ_CHECK;
        end else if (key_press[KEY_RIGHT_1]) begin
          w_try_dir_n = r_cur_dir + DIR_LEN'(1);
          w_kind_n    = K_ROT;
          w_state_n   = SEQ_CHECK;
        end else if (key_press[KEY_LEFT]) begin
          w_try_pos_n = make_pos(w_cur_x - COORD_LEN'(1), w_cur_y);
          w_kind_n    = K_LEFT;
          w_state_n   = SEQ_CHECK;
        end else if (key_press[KEY_RIGHT]) begin
          w_try_pos_n = make_pos(w_cur_x + COORD_LEN'(1), w_cur_y);
          w_kind_n    = K_RIGHT;
          w_state_n   = SEQ_CHECK;
        end else if (key_press[KEY_DOWN]) begin
          w_try_pos_n = make_pos(w_cur_x, w_cur_y - COORD_LEN'(1));
          w_kind_n    = K_DOWN;
          w_state_n   = SEQ_CHECK;
        end
      end
      SEQ_CHECK: begin
        if (!is_collided) begin
          w_cur_pos_n  = r_try_pos;
          w_cur_dir_n  = r_try_dir;
          w_cur_type_n = r_try_type;
          w_grav_clr   = (r_kind == K_GRAV) || (r_kind == K_DOWN);
          w_state_n    = SEQ_WAIT;
        end else begin
          case (r_kind)
            K_GRAV, K_DOWN: w_state_n = SEQ_PLACE;
            K_SPAWN:        w_state_n = SEQ_OVER;
            default: begin
              w_try_pos_n  = r_cur_pos;
              w_try_dir_n  = r_cur_dir;
              w_try_type_n = r_cur_type;
              w_state_n    = SEQ_WAIT;
            end
          endcase
        end
      end
      SEQ_PLACE: w_state_n = SEQ_CLEAR;
      SEQ_CLEAR: begin
        w_lines_n  = sat_add16(r_lines, {13'd0, w_n_clr});
        w_score_n  = sat_add16(r_score, score_tab(w_n_clr));
        w_grav_clr = 1'b1;
        w_state_n  = SEQ_SPAWN;
      end
      default: w_state_n = SEQ_IDLE;
    endcase
  end

  // State and brick registers; reset returns everything to the spawn brick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= SEQ_IDLE;
      r_kind     <= K_SPAWN;
      r_cur_pos  <= SPAWN_POS;
      r_cur_dir  <= '0;
      r_cur_type <= BRICK_I;
      r_try_pos  <= SPAWN_POS;
      r_try_dir  <= '0;
      r_try_type <= BRICK_I;
      r_lines    <= '0;
      r_score    <= '0;
    end else begin
      r_state    <= w_state_n;
      r_kind     <= w_kind_n;
      r_cur_pos  <= w_cur_pos_n;
      r_cur_dir  <= w_cur_dir_n;
      r_cur_type <= w_cur_type_n;
      r_try_pos  <= w_try_pos_n;
      r_try_dir  <= w_try_dir_n;
      r_try_type <= w_try_type_n;
      r_lines    <= w_lines_n;
      r_score    <= w_score_n;
    end
  end

  assign cur_pos   = r_cur_pos;
  assign cur_dir   = r_cur_dir;
  assign cur_type  = r_cur_type;
  assign try_pos   = r_try_pos;
  assign try_dir   = r_try_dir;
  assign try_type  = r_try_type;
  assign lines     = r_lines;
  assign score     = r_score;
  assign place_en  = (r_state == SEQ_PLACE);
  assign clear_en  = (r_state == SEQ_CLEAR);
  assign game_over = (r_state == SEQ_OVER);
  assign state     = r_state;

endmodule
